// File: rtl/obuf_drain_if.sv
// rtl/obuf_drain_if.sv - biased-row output stream between obuf_drain and the post-processing/DMA path
interface obuf_drain_if #(
  parameter int ARRAY_M   = 4,
  parameter int ACC_WIDTH = 48
);
  logic                         out_valid;
  logic                         out_ready;
  logic [ARRAY_M*ACC_WIDTH-1:0] out_data;
  logic                         out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/obuf_drain.sv
// rtl/obuf_drain.sv - obuf read-side drain: one bias row added lane-wise to num_rows obuf rows, streamed out
// Optional build macro OBUF_DRAIN_RELU_EN clamps negative lanes to zero after the bias add.
module obuf_drain #(
  parameter int ARRAY_M         = 4,
  parameter int ACC_WIDTH       = 48,
  parameter int BIAS_WIDTH      = 32,
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int BBUF_ADDR_WIDTH = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [OBUF_ADDR_WIDTH-1:0]    base_addr,
  input  logic [CNT_WIDTH-1:0]          num_rows,
  input  logic [BBUF_ADDR_WIDTH-1:0]    bias_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          obuf_read_req,
  output logic [OBUF_ADDR_WIDTH-1:0]    obuf_read_addr,
  input  logic [ARRAY_M*ACC_WIDTH-1:0]  obuf_read_data,
  output logic                          bbuf_read_req,
  output logic [BBUF_ADDR_WIDTH-1:0]    bbuf_read_addr,
  input  logic [ARRAY_M*BIAS_WIDTH-1:0] bbuf_read_data,
  obuf_drain_if.master                  ostream
);

  typedef enum logic [2:0] {IDLE, BIAS, BWAIT, STREAM, FIN} state_t;

  state_t                        state, state_next;
  logic [OBUF_ADDR_WIDTH-1:0]    base_q;
  logic [CNT_WIDTH-1:0]          num_q;
  logic [BBUF_ADDR_WIDTH-1:0]    bias_addr_q;
  logic [ARRAY_M*BIAS_WIDTH-1:0] bias_q;
  logic [CNT_WIDTH-1:0]          issued;
  logic [CNT_WIDTH-1:0]          drained;
  logic                          inflight;
  logic [ARRAY_M*ACC_WIDTH-1:0]  fifo_mem [2];
  logic                          wr_ptr, rd_ptr;
  logic [1:0]                    fifo_count;

  logic                          pop;
  logic                          last_row;
  logic [2:0]                    occupancy;
  logic [ACC_WIDTH-1:0]          lane;
  logic [ARRAY_M*ACC_WIDTH-1:0]  biased;

  assign ostream.out_valid = (fifo_count != 2'd0);
  assign ostream.out_data  = fifo_mem[rd_ptr];
  assign pop               = ostream.out_valid & ostream.out_ready;
  assign last_row          = (drained == num_q - CNT_WIDTH'(1));
  assign ostream.out_last  = ostream.out_valid & last_row;
  assign obuf_read_addr    = base_q + OBUF_ADDR_WIDTH'(issued);
  assign bbuf_read_addr    = bias_addr_q;

  // Rows already buffered plus the one in flight, net of this cycle's pop, must leave a free FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    biased = '0;
    lane   = '0;
    for (int i = 0; i < ARRAY_M; i++) begin
      lane = obuf_read_data[i*ACC_WIDTH +: ACC_WIDTH]
           + {{(ACC_WIDTH-BIAS_WIDTH){bias_q[i*BIAS_WIDTH+BIAS_WIDTH-1]}},
              bias_q[i*BIAS_WIDTH +: BIAS_WIDTH]};
`ifdef OBUF_DRAIN_RELU_EN
      biased[i*ACC_WIDTH +: ACC_WIDTH] = lane[ACC_WIDTH-1] ? '0 : lane;
`else
      biased[i*ACC_WIDTH +: ACC_WIDTH] = lane;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    done          = 1'b0;
    bbuf_read_req = 1'b0;
    obuf_read_req = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = BIAS;
      end
      BIAS: begin
        busy          = 1'b1;
        bbuf_read_req = 1'b1;
        state_next    = BWAIT;
      end
      BWAIT: begin
        // The first obuf read overlaps the bias capture so data meets a valid bias register.
        busy          = 1'b1;
        obuf_read_req = (issued < num_q) && (occupancy < 3'd2);
        state_next    = (num_q == '0) ? FIN : STREAM;
      end
      STREAM: begin
        busy          = 1'b1;
        obuf_read_req = (issued < num_q) && (occupancy < 3'd2);
        if (pop && last_row) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      bias_addr_q <= '0;
      bias_q      <= '0;
      issued      <= '0;
      drained     <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state      <= state_next;
      inflight   <= obuf_read_req;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (state == IDLE && start) begin
        base_q      <= base_addr;
        num_q       <= num_rows;
        bias_addr_q <= bias_addr;
        issued      <= '0;
        drained     <= '0;
      end
      if (state == BWAIT) bias_q <= bbuf_read_data;
      if (obuf_read_req) issued <= issued + CNT_WIDTH'(1);
      if (inflight) begin
        fifo_mem[wr_ptr] <= biased;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        drained <= drained + CNT_WIDTH'(1);
      end
    end
  end

endmodule
